// File: rtl/mux16_rr_sched.sv
// rtl/mux16_rr_sched.sv - round-robin scheduler sharing one 16:1 single-bit mux among 16 requesters
module mux16_rr_sched #(
   parameter int SETTLE_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        mux_out,
   output logic [3:0]  sel,
   output logic [15:0] gnt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_data,
   output logic [15:0] ack,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SETTLE, OFFER} state_t;

   state_t     state;
   logic [3:0] ptr;
   logic [3:0] cnt;
   logic [3:0] win;
   logic [3:0] idx;
   logic       found;

   // First requester at or after ptr, wrapping modulo 16.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = ptr;
      for (int i = 0; i < 16; i++) begin
         idx = ptr + i[3:0];
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 4'd0;
         cnt       <= 4'd0;
         sel       <= 4'd0;
         gnt       <= 16'd0;
         out_valid <= 1'b0;
         out_data  <= 1'b0;
         ack       <= 16'd0;
         busy      <= 1'b0;
      end else begin
         ack <= 16'd0;
         case (state)
            IDLE: begin
               if (found) begin
                  sel   <= win;
                  gnt   <= 16'd1 << win;
                  cnt   <= 4'(SETTLE_CYC);
                  busy  <= 1'b1;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  out_data  <= mux_out;
                  out_valid <= 1'b1;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  gnt       <= 16'd0;
                  ack       <= 16'd1 << sel;
                  ptr       <= sel + 4'd1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb/tb_mux16_rr_sched.sv - directed vector bench for mux16_rr_sched
module tb_mux16_rr_sched;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] mux_in;
   logic        mux_out;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        out_valid;
   logic        out_ready;
   logic        out_data;
   logic [15:0] ack;
   logic        busy;

   int n_vec;
   int n_err;
   logic prev_b;

   typedef struct {
      logic [15:0] req;
      logic [15:0] mux;
      logic [3:0]  sel;
      logic        data;
   } vec_t;

   vec_t vt[11];

   mux16_rr_sched #(.SETTLE_CYC(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mux_out   (mux_out),
      .sel       (sel),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ack       (ack),
      .busy      (busy)
   );

   assign mux_out = mux_in[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      prev_b = 1'b0;
   endtask

   task automatic next_grant(input logic [3:0] exp);
      int n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         @(posedge clk);
         #1;
         n++;
         if (busy && !prev_b) seen = 1'b1;
         prev_b = busy;
      end
      chk("rr_grant_seen", {31'd0, seen}, 32'd1);
      chk("rr_sel", {28'd0, sel}, {28'd0, exp});
      chk("rr_gnt", {16'd0, gnt}, {16'd0, 16'd1 << exp});
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 20);
   endtask

   task automatic run_txn(input vec_t v);
      int n;
      @(negedge clk);
      req       = v.req;
      mux_in    = v.mux;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("txn_sel", {28'd0, sel}, {28'd0, v.sel});
      chk("txn_gnt", {16'd0, gnt}, {16'd0, 16'd1 << v.sel});
      chk("txn_busy", {31'd0, busy}, 32'd1);
      req = 16'd0;
      wait_valid(n);
      chk("txn_latency", n, 32'd2);
      chk("txn_data", {31'd0, out_data}, {31'd0, v.data});
      @(posedge clk);
      #1;
      chk("txn_ack", {16'd0, ack}, {16'd0, 16'd1 << v.sel});
      chk("txn_valid_low", {31'd0, out_valid}, 32'd0);
      chk("txn_gnt_low", {16'd0, gnt}, 32'd0);
      @(posedge clk);
      #1;
      chk("txn_ack_clear", {16'd0, ack}, 32'd0);
      chk("txn_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      n_vec = 0;
      n_err = 0;
      prev_b = 1'b0;

      vt[0]  = '{16'h0020, 16'h0020, 4'd5,  1'b1};
      vt[1]  = '{16'h0020, 16'h0000, 4'd5,  1'b0};
      vt[2]  = '{16'h0021, 16'hFFFF, 4'd0,  1'b1};
      vt[3]  = '{16'h8000, 16'h7FFF, 4'd15, 1'b0};
      vt[4]  = '{16'h8001, 16'h0001, 4'd0,  1'b1};
      vt[5]  = '{16'h8001, 16'h8000, 4'd15, 1'b1};
      vt[6]  = '{16'h0300, 16'h0200, 4'd8,  1'b0};
      vt[7]  = '{16'h0300, 16'h0200, 4'd9,  1'b1};
      vt[8]  = '{16'h0300, 16'h0100, 4'd8,  1'b1};
      vt[9]  = '{16'hFFFF, 16'h0000, 4'd9,  1'b0};
      vt[10] = '{16'h0100, 16'h0100, 4'd8,  1'b1};

      // Reset held with every request asserted.
      rst_n     = 1'b0;
      req       = 16'hFFFF;
      mux_in    = 16'h0000;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", {28'd0, sel}, 32'd0);
      chk("rst_gnt", {16'd0, gnt}, 32'd0);
      chk("rst_ack", {16'd0, ack}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin with all requesting, then only 0 and 15.
      for (int k = 0; k < 16; k++) next_grant(k[3:0]);
      @(negedge clk);
      req = 16'h8001;
      next_grant(4'd0);
      next_grant(4'd15);
      req = 16'd0;
      do_reset();

      for (int i = 0; i < 11; i++) run_txn(vt[i]);

      // Backpressure with a toggling mux input.
      @(negedge clk);
      req       = 16'h0004;
      mux_in    = 16'h0004;
      out_ready = 1'b0;
      wait_valid(n);
      req = 16'd0;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         mux_in = ~mux_in;
         @(posedge clk);
         #1;
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_data", {31'd0, out_data}, 32'd1);
         chk("bp_hold_sel", {28'd0, sel}, 32'd2);
         chk("bp_hold_gnt", {16'd0, gnt}, 32'h0004);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_ack", {16'd0, ack}, 32'h0004);
      @(posedge clk);
      #1;
      chk("bp_ack_clear", {16'd0, ack}, 32'd0);

      // Asynchronous reset while offering.
      @(negedge clk);
      req       = 16'h0001;
      mux_in    = 16'h0000;
      out_ready = 1'b0;
      wait_valid(n);
      req = 16'd0;
      chk("mid_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_gnt", {16'd0, gnt}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_sel", {28'd0, sel}, 32'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk("mid_rst_noack", {16'd0, ack}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
